// File: rtl/regfile_pkg.sv
// Shared types for the multi-port register file: clear-sweep FSM states
// and default width/depth localparams used as parameter defaults.
package regfile_pkg;

  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear-sweep controller: IDLE -> SWEEP (one entry per cycle) -> DONE -> IDLE.
// Ports: clk, rst (sync, active-low), clr_req in; clr_busy, clr_ack, idle,
//        sweep_start, sweep_we, sweep_addr out to the array.
import regfile_pkg::*;

module regfile_clr_fsm #(
  parameter int ADDR_W = REGFILE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_ack,
  output logic              idle,
  output logic              sweep_start,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sweep_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d     = SWEEP;
          cnt_d       = '0;
          sweep_start = 1'b1;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        // terminal on the last index, not on the wrap
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clr_busy   = (state_q == SWEEP);
  assign clr_ack    = (state_q == DONE);
  assign idle       = (state_q == IDLE);
  assign sweep_we   = (state_q == SWEEP);
  assign sweep_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD async reads, two prioritised writes
// (wr1 wins), busy scoreboard (alloc/writeback) and a clear sweep.
// Ports: rd_addr/rd_data/rd_busy (packed per port), wr0_*, wr1_*,
//        alloc_en/alloc_addr, clr_req/clr_busy/clr_ack; rst sync active-low.
// Option: define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
import regfile_pkg::*;

module regfile_mp #(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_ack
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;

  logic              idle;
  logic              sweep_start;
  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;

  regfile_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk         (clk),
    .rst         (rst),
    .clr_req     (clr_req),
    .clr_busy    (clr_busy),
    .clr_ack     (clr_ack),
    .idle        (idle),
    .sweep_start (sweep_start),
    .sweep_we    (sweep_we),
    .sweep_addr  (sweep_addr)
  );

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (idle) begin
      if (wr0_en) begin
        mem_d[wr0_addr]  = wr0_data;
        busy_d[wr0_addr] = 1'b0;
      end
      if (wr1_en) begin
        mem_d[wr1_addr]  = wr1_data;
        busy_d[wr1_addr] = 1'b0;
      end
      // alloc after writes: the newer producer keeps the entry busy
      if (alloc_en) busy_d[alloc_addr] = 1'b1;
    end
    if (sweep_start) busy_d = '0;
    if (sweep_we) mem_d[sweep_addr] = '0;
    if (ZERO_REG != 0) begin
      mem_d[0]  = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;
    logic              z;

    assign a = rd_addr[g*ADDR_W +: ADDR_W];
    assign z = (ZERO_REG != 0) && (a == '0);

    always_comb begin
      d = mem_q[a];
      b = busy_q[a];
      if (z) d = '0;
`ifdef REGFILE_BYPASS_EN
      if (idle && !z) begin
        if (wr1_en && (wr1_addr == a)) begin
          d = wr1_data;
          b = 1'b0;
        end else if (wr0_en && (wr0_addr == a)) begin
          d = wr0_data;
          b = 1'b0;
        end
      end
`endif
    end

    assign rd_data[g*DATA_W +: DATA_W] = d;
    assign rd_busy[g]                  = b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table with a scoreboard queue,
// plus sequences for reset, bypass, clear sweep and reset mid-sweep.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr0_en, wr1_en, alloc_en, clr_req;
  logic [4:0]  wr0_addr, wr1_addr, alloc_addr;
  logic [31:0] wr0_data, wr1_data;
  logic        clr_busy, clr_ack;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr0_en     (wr0_en),
    .wr0_addr   (wr0_addr),
    .wr0_data   (wr0_data),
    .wr1_en     (wr1_en),
    .wr1_addr   (wr1_addr),
    .wr1_data   (wr1_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_ack    (clr_ack)
  );

  typedef struct {
    logic        w0e;
    logic [4:0]  w0a;
    logic [31:0] w0d;
    logic        w1e;
    logic [4:0]  w1a;
    logic [31:0] w1d;
    logic        ae;
    logic [4:0]  aa;
    logic [4:0]  ca;
    logic [31:0] ed;
    logic        eb;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] d;
    logic        b;
  } exp_t;

  localparam int NV = 11;
  vec_t vt [NV];
  exp_t sbq [$];

  function automatic vec_t mkv(int w0e, int w0a, int w0d,
                               int w1e, int w1a, int w1d,
                               int ae, int aa, int ca,
                               int ed, int eb);
    vec_t v;
    v.w0e = 1'(w0e); v.w0a = 5'(w0a); v.w0d = 32'(w0d);
    v.w1e = 1'(w1e); v.w1a = 5'(w1a); v.w1d = 32'(w1d);
    v.ae  = 1'(ae);  v.aa  = 5'(aa);  v.ca  = 5'(ca);
    v.ed  = 32'(ed); v.eb  = 1'(eb);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic quiet();
    wr0_en = 1'b0; wr1_en = 1'b0; alloc_en = 1'b0; clr_req = 1'b0;
    wr0_addr = '0; wr1_addr = '0; alloc_addr = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int bc, ac, ack_at, nz;
  exp_t e;

  initial begin
    rst = 1'b0;
    rd_addr = '0;
    quiet();
    tick(); tick();
    rst = 1'b1;

    // reset test: write + alloc r5, then sync reset
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEAD;
    alloc_en = 1'b1; alloc_addr = 5'd5;
    rd_addr = {5'd5, 5'd5};
    tick(); quiet();
    chk("pre_rst_r5", rd_data[31:0], 32'hDEAD);
    chk("pre_rst_busy", 32'(rd_busy[0]), 32'd1);
    rst = 1'b0;
    wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h1234;
    tick(); quiet();
    rst = 1'b1;
    chk("rst_r5", rd_data[31:0], 32'h0);
    chk("rst_busy", 32'(rd_busy), 32'h0);
    chk("rst_clr_busy", 32'(clr_busy), 32'h0);
    chk("rst_clr_ack", 32'(clr_ack), 32'h0);

    // vector table
    vt[0]  = mkv(1, 3, 'h11,   1, 3, 'h22, 0, 0, 3,  'h22,   0);
    vt[1]  = mkv(0, 0, 0,      1, 0, 'hFFFF, 0, 0, 0, 0,     0);
    vt[2]  = mkv(0, 0, 0,      0, 0, 0,    1, 7, 7,  0,      1);
    vt[3]  = mkv(1, 7, 'h5,    0, 0, 0,    0, 0, 7,  'h5,    0);
    vt[4]  = mkv(0, 0, 0,      1, 7, 'h6,  1, 7, 7,  'h6,    1);
    vt[5]  = mkv(1, 4, 'h44,   1, 8, 'h88, 0, 0, 4,  'h44,   0);
    vt[6]  = mkv(0, 0, 0,      0, 0, 0,    0, 0, 8,  'h88,   0);
    vt[7]  = mkv(0, 0, 0,      0, 0, 0,    1, 0, 0,  0,      0);
    vt[8]  = mkv(1, 31, 'hCAFE, 0, 0, 0,   0, 0, 31, 'hCAFE, 0);
    vt[9]  = mkv(0, 0, 0,      1, 7, 'h77, 0, 0, 7,  'h77,   0);
    vt[10] = mkv(1, 3, 'h33,   0, 0, 0,    1, 3, 3,  'h33,   1);

    for (int i = 0; i < NV; i++) begin
      wr0_en = vt[i].w0e; wr0_addr = vt[i].w0a; wr0_data = vt[i].w0d;
      wr1_en = vt[i].w1e; wr1_addr = vt[i].w1a; wr1_data = vt[i].w1d;
      alloc_en = vt[i].ae; alloc_addr = vt[i].aa;
      rd_addr = {vt[i].ca, vt[i].ca};
      sbq.push_back('{idx: i, d: vt[i].ed, b: vt[i].eb});
      tick(); quiet();
      e = sbq.pop_front();
      chk($sformatf("vec%0d_rd0", e.idx), rd_data[31:0], e.d);
      chk($sformatf("vec%0d_rd1", e.idx), rd_data[63:32], e.d);
      chk($sformatf("vec%0d_busy", e.idx), 32'(rd_busy[0]), 32'(e.b));
    end

    // bypass: r9 busy, then wr1 r9 with read on the same cycle
    alloc_en = 1'b1; alloc_addr = 5'd9;
    tick(); quiet();
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'hAB;
    rd_addr = {5'd9, 5'd9};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same_data", rd_data[31:0], 32'hAB);
    chk("byp_same_busy", 32'(rd_busy[0]), 32'd0);
`else
    chk("byp_same_data", rd_data[31:0], 32'h0);
    chk("byp_same_busy", 32'(rd_busy[0]), 32'd1);
`endif
    tick(); quiet();
    chk("byp_next_data", rd_data[31:0], 32'hAB);
    chk("byp_next_busy", 32'(rd_busy[0]), 32'd0);

    // clear sweep: fill r1..r31, alloc r12
    for (int i = 1; i < 32; i++) begin
      wr0_en = 1'b1; wr0_addr = 5'(i); wr0_data = 32'h100 + 32'(i);
      tick();
    end
    quiet();
    alloc_en = 1'b1; alloc_addr = 5'd12;
    tick(); quiet();
    rd_addr = {5'd20, 5'd12};
    #1;
    chk("fill_r12_busy", 32'(rd_busy[0]), 32'd1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("sweep_busy_clr", 32'(rd_busy[0]), 32'd0);
    chk("sweep_partial_r20", rd_data[63:32], 32'h114);
    bc = 0; ac = 0; ack_at = -1;
    for (int k = 0; k < 40; k++) begin
      if (clr_busy) bc++;
      if (clr_ack) begin
        ac++;
        if (ack_at < 0) ack_at = k;
      end
      wr0_en = clr_busy | clr_ack;
      wr0_addr = 5'd2; wr0_data = 32'h999;
      alloc_en = clr_busy | clr_ack;
      alloc_addr = 5'd2;
      tick();
    end
    quiet();
    chk("sweep_busy_cycles", 32'(bc), 32'd32);
    chk("sweep_ack_count", 32'(ac), 32'd1);
    chk("sweep_ack_at", 32'(ack_at), 32'd32);
    nz = 0;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      if (rd_data != 64'h0 || rd_busy != 2'b00) nz++;
    end
    chk("sweep_all_zero", 32'(nz), 32'd0);
    rd_addr = {5'd2, 5'd2};
    #1;
    chk("sweep_wr0_dropped", rd_data[31:0], 32'h0);
    chk("sweep_alloc_dropped", 32'(rd_busy[0]), 32'd0);

    // reset mid-sweep
    wr0_en = 1'b1; wr0_addr = 5'd20; wr0_data = 32'h2020;
    tick(); quiet();
    alloc_en = 1'b1; alloc_addr = 5'd21;
    tick(); quiet();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_clr_busy", 32'(clr_busy), 32'd0);
    bc = 0; ac = 0;
    for (int k = 0; k < 40; k++) begin
      if (clr_busy) bc++;
      if (clr_ack) ac++;
      tick();
    end
    chk("midrst_no_ack", 32'(ac), 32'd0);
    chk("midrst_no_busy", 32'(bc), 32'd0);
    rd_addr = {5'd21, 5'd20};
    #1;
    chk("midrst_r20", rd_data[31:0], 32'h0);
    chk("midrst_r21_busy", 32'(rd_busy[1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
